// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state enum, control encodings for the MIPS multicycle controller
// Optional JAL_LINK_EN makes jal a legal opcode.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] RDST_RT = 2'b00;
  localparam logic [1:0] RDST_RD = 2'b01;
  localparam logic [1:0] RDST_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond_eq;
    logic       pc_write_cond_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    case (op)
      OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: return 1'b1;
`ifdef JAL_LINK_EN
      OP_JAL: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational map from state/opcode/mem_ready to control outputs
// Optional JAL_LINK_EN adds the $31 link write in JUMP for jal.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_ONE;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.ir_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Speculatively form PC+1+imm so BRANCH can use ALUOut directly.
        o_ctrl.alu_src_b  = SRCB_BROFF;
        o_ctrl.alu_op     = ALU_ADD;
        o_ctrl.illegal_op = !op_is_legal(i_opcode);
      end
      S_MEM_ADDR, S_ADDI_EX: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RDST_RT;
        o_ctrl.mem_to_reg = M2R_MDR;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.iord       = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RDST_RD;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a        = 1'b1;
        o_ctrl.alu_src_b        = SRCB_RT;
        o_ctrl.alu_op           = ALU_SUB;
        o_ctrl.pc_source        = PCSRC_ALUOUT;
        o_ctrl.pc_write_cond_eq = (i_opcode == OP_BEQ);
        o_ctrl.pc_write_cond_ne = (i_opcode == OP_BNE);
        o_ctrl.instr_done       = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
`ifdef JAL_LINK_EN
        if (i_opcode == OP_JAL) begin
          o_ctrl.reg_write  = 1'b1;
          o_ctrl.reg_dst    = RDST_RA;
          o_ctrl.mem_to_reg = M2R_PC;
        end
`endif
      end
      S_ADDI_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = RDST_RT;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM: state register, next-state, reset gating
// Define JAL_LINK_EN to make jal a legal jump-and-link; otherwise jal is illegal.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_pc_write_cond_eq,
  output logic       o_pc_write_cond_ne,
  output logic [1:0] o_pc_source,
  output logic       o_iord,
  output logic       o_mem_read,
  output logic       o_mem_write,
  output logic       o_ir_write,
  output logic       o_reg_write,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_instr_done,
  output logic       o_illegal_op,
  output logic [3:0] o_state
);

  state_t r_state;
  ctrl_t  w_ctrl;
  ctrl_t  w_out;

  mips_ctrl_decode u_decode (
    .i_state     (r_state),
    .i_opcode    (i_opcode),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  // Reset forces every output low in the same cycle, abandoning any access in flight.
  assign w_out = i_reset ? '0 : w_ctrl;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:     if (i_mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (i_opcode)
            OP_LW, OP_SW:   r_state <= S_MEM_ADDR;
            OP_R:           r_state <= S_EXECUTE;
            OP_BEQ, OP_BNE: r_state <= S_BRANCH;
            OP_J:           r_state <= S_JUMP;
`ifdef JAL_LINK_EN
            OP_JAL:         r_state <= S_JUMP;
`endif
            OP_ADDI:        r_state <= S_ADDI_EX;
            default:        r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR:  r_state <= (i_opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (i_mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE: if (i_mem_ready) r_state <= S_FETCH;
        S_EXECUTE:   r_state <= S_ALU_WB;
        S_ADDI_EX:   r_state <= S_ADDI_WB;
        default:     r_state <= S_FETCH;
      endcase
    end
  end

  assign o_pc_write         = w_out.pc_write;
  assign o_pc_write_cond_eq = w_out.pc_write_cond_eq;
  assign o_pc_write_cond_ne = w_out.pc_write_cond_ne;
  assign o_pc_source        = w_out.pc_source;
  assign o_iord             = w_out.iord;
  assign o_mem_read         = w_out.mem_read;
  assign o_mem_write        = w_out.mem_write;
  assign o_ir_write         = w_out.ir_write;
  assign o_reg_write        = w_out.reg_write;
  assign o_reg_dst          = w_out.reg_dst;
  assign o_mem_to_reg       = w_out.mem_to_reg;
  assign o_alu_src_a        = w_out.alu_src_a;
  assign o_alu_src_b        = w_out.alu_src_b;
  assign o_alu_op           = w_out.alu_op;
  assign o_instr_done       = w_out.instr_done;
  assign o_illegal_op       = w_out.illegal_op;
  assign o_state            = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl with per-instruction reference model
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       cond_eq;
    logic       cond_ne;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  typedef struct {
    ctl_t       c;
    logic [3:0] st;
    bit         chk_st;
    string      tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b1;

  logic       pc_write, cond_eq, cond_ne, iord, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, instr_done, illegal_op;
  logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b, alu_op;
  logic [3:0] state;
  ctl_t       got;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [5:0] ops [8] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000101, 6'b000010, 6'b000011, 6'b001000};

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_opcode           (opcode),
    .i_mem_ready        (mem_ready),
    .o_pc_write         (pc_write),
    .o_pc_write_cond_eq (cond_eq),
    .o_pc_write_cond_ne (cond_ne),
    .o_pc_source        (pc_source),
    .o_iord             (iord),
    .o_mem_read         (mem_read),
    .o_mem_write        (mem_write),
    .o_ir_write         (ir_write),
    .o_reg_write        (reg_write),
    .o_reg_dst          (reg_dst),
    .o_mem_to_reg       (mem_to_reg),
    .o_alu_src_a        (alu_src_a),
    .o_alu_src_b        (alu_src_b),
    .o_alu_op           (alu_op),
    .o_instr_done       (instr_done),
    .o_illegal_op       (illegal_op),
    .o_state            (state)
  );

  assign got = {pc_write, cond_eq, cond_ne, pc_source, iord, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, instr_done, illegal_op};

  // Monitor: checks each cycle that has an expectation queued, mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (got !== e.c || (e.chk_st && state !== e.st)) begin
        n_bad++;
        $display("FAIL %s: got ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                 e.tag, got, state, e.c, e.st);
      end
    end
  end

  function automatic bit legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b001000: return 1'b1;
`ifdef JAL_LINK_EN
      6'b000011: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input bit rdy, input bit r, input logic [5:0] op, input ctl_t c,
                     input int st, input bit chk, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    mem_ready = rdy;
    rst       = r;
    opcode    = op;
    e.c = c; e.st = st[3:0]; e.chk_st = chk; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic do_fetch(input int waits);
    ctl_t c;
    c = '0; c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    for (int i = 0; i < waits; i++) cyc(1'b0, 1'b0, 6'($urandom), c, 0, 1'b1, "fetch_wait");
    c.pc_write = 1'b1; c.ir_write = 1'b1;
    cyc(1'b1, 1'b0, 6'($urandom), c, 0, 1'b1, "fetch_go");
  endtask

  task automatic do_decode(input logic [5:0] op);
    ctl_t c;
    c = '0; c.alu_src_b = 2'b11; c.illegal_op = !legal(op);
    cyc(1'($urandom), 1'b0, op, c, 1, 1'b1, "decode");
  endtask

  task automatic do_mem_addr(input logic [5:0] op);
    ctl_t c;
    c = '0; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
    cyc(1'($urandom), 1'b0, op, c, 2, 1'b1, "mem_addr");
  endtask

  task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
    ctl_t c;
    do_fetch(fw);
    do_decode(op);
    if (!legal(op)) return;
    c = '0;
    case (op)
      6'b100011: begin
        do_mem_addr(op);
        c.iord = 1'b1; c.mem_read = 1'b1;
        for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, op, c, 3, 1'b1, "mem_read_wait");
        cyc(1'b1, 1'b0, op, c, 3, 1'b1, "mem_read_go");
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'b01; c.instr_done = 1'b1;
        cyc(1'($urandom), 1'b0, op, c, 4, 1'b1, "mem_wb");
      end
      6'b101011: begin
        do_mem_addr(op);
        c.iord = 1'b1; c.mem_write = 1'b1;
        for (int i = 0; i < mw; i++) cyc(1'b0, 1'b0, op, c, 5, 1'b1, "mem_write_wait");
        c.instr_done = 1'b1;
        cyc(1'b1, 1'b0, op, c, 5, 1'b1, "mem_write_go");
      end
      6'b000000: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b10;
        cyc(1'($urandom), 1'b0, op, c, 6, 1'b1, "execute");
        c = '0; c.reg_write = 1'b1; c.reg_dst = 2'b01; c.instr_done = 1'b1;
        cyc(1'($urandom), 1'b0, op, c, 7, 1'b1, "alu_wb");
      end
      6'b000100, 6'b000101: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.instr_done = 1'b1;
        c.cond_eq = (op == 6'b000100); c.cond_ne = (op == 6'b000101);
        cyc(1'($urandom), 1'b0, op, c, 8, 1'b1, op[0] ? "bne" : "beq");
      end
      6'b000010, 6'b000011: begin
        c.pc_write = 1'b1; c.pc_source = 2'b10; c.instr_done = 1'b1;
        if (op == 6'b000011) begin
          c.reg_write = 1'b1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
        cyc(1'($urandom), 1'b0, op, c, 9, 1'b1, op[0] ? "jal" : "j");
      end
      default: begin
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
        cyc(1'($urandom), 1'b0, op, c, 10, 1'b1, "addi_ex");
        c = '0; c.reg_write = 1'b1; c.instr_done = 1'b1;
        cyc(1'($urandom), 1'b0, op, c, 11, 1'b1, "addi_wb");
      end
    endcase
  endtask

  task automatic reset_in_mem_read();
    ctl_t c;
    do_fetch(0);
    do_decode(6'b100011);
    do_mem_addr(6'b100011);
    c = '0; c.iord = 1'b1; c.mem_read = 1'b1;
    cyc(1'b0, 1'b0, 6'b100011, c, 3, 1'b1, "mem_read_wait");
    cyc(1'b0, 1'b0, 6'b100011, c, 3, 1'b1, "mem_read_wait");
    cyc(1'b1, 1'b1, 6'b100011, '0, 3, 1'b1, "reset_mid_read");
  endtask

  initial begin
    logic [5:0] op;
    cyc(1'b1, 1'b1, 6'd0, '0, 0, 1'b0, "reset_cycle0");
    cyc(1'b1, 1'b1, 6'd0, '0, 0, 1'b1, "reset_cycle1");
    run_instr(6'b100011, 0, 0);
    run_instr(6'b000000, 3, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000101, 1, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b000011, 0, 0);
    run_instr(6'b001000, 0, 0);
    run_instr(6'b101011, 0, 2);
    run_instr(6'b100011, 1, 3);
    run_instr(6'b111111, 0, 0);
    reset_in_mem_read();
    run_instr(6'b000000, 0, 0);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) op = 6'($urandom);
      else op = ops[$urandom_range(0, 7)];
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS datapath. It sequences the word-addressed PC, instruction register, register file, ALU and shared memory through fetch, decode, execute, memory and writeback steps. It issues PC update enables and selects: PC+1, branch target PC+1+imm, and jump target. It sits beside the PC unit and the datapath muxes and owns every write enable in the core.

## Interface
No parameters.
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond_eq  out  1  PC load if ALU zero=1 (beq)
- pc_write_cond_ne  out  1  PC load if ALU zero=0 (bne)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- iord  out  1  memory address: 0 PC, 1 ALUOut
- mem_read, mem_write  out  1 each  memory request, level, held until mem_ready
- ir_write  out  1  IR load
- reg_write  out  1  register file write
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 1, 10 sign-ext imm, 11 sign-ext imm (branch offset)
- alu_op  out  2  00 add, 01 sub, 10 use funct
- instr_done  out  1  one-cycle pulse in last state of an instruction
- illegal_op  out  1  one-cycle pulse on unrecognised opcode
- state  out  4  current state, debug

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, jal 000011, addi 001000.
- States/encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11. Codes 12–15 unreachable; they recover to FETCH.
- Unlisted outputs are 0 in every state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00. pc_write=ir_write=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, so ALUOut=PC+1+imm. Dispatch on opcode: lw/sw→MEM_ADDR, R→EXECUTE, beq/bne→BRANCH, j/jal→JUMP, addi→ADDI_EX. Any other opcode: illegal_op=1, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. lw→MEM_READ, sw→MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Advance to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01.
- MEM_WRITE: mem_write=1, iord=1. Go to FETCH on mem_ready; instr_done=mem_ready.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. ALU_WB: reg_write=1, reg_dst=01.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01. beq sets cond_eq=1; bne sets cond_ne=1; never both.
- JUMP: pc_write=1, pc_source=10.
- ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00. ADDI_WB: reg_write=1, reg_dst=00.
- Terminal states MEM_WB, ALU_WB, BRANCH, JUMP and ADDI_WB assert instr_done and return to FETCH.
- mem_read and mem_write are never asserted together.

## Timing
- Moore outputs decoded from state. Exception: FETCH pc_write/ir_write and the MEM_WRITE exit are gated by mem_ready in the same cycle.
- Latency with zero wait (mem_ready=1), in cycles: j/beq/bne 3, R/sw/addi 4, lw 5. Each wait cycle adds 1 in FETCH, MEM_READ or MEM_WRITE.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Reset: every enable output and both pulses are 0 while reset=1. pc_source, iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b and alu_op read 0. State becomes FETCH at the next edge.
- Reset mid-request abandons the access; no enable fires during the reset cycle.

## Configuration
- JAL_LINK_EN defined: jal goes DECODE→JUMP. JUMP additionally asserts reg_write=1, reg_dst=10, mem_to_reg=10, so $31 receives PC+1.
- JAL_LINK_EN undefined: jal is an illegal opcode (illegal_op pulse, back to FETCH), and reg_dst/mem_to_reg never take the value 10.

## Structure
- Package mips_ctrl_pkg holds:
  - opcode constants
  - state enum
  - alu_op, pc_source, alu_src_b, reg_dst and mem_to_reg encodings
- Sub-module mips_ctrl_decode: purely combinational, maps state, opcode and mem_ready to control outputs. The top module keeps the state register and next-state logic.

## Test plan
- Reset held 2 cycles, mem_ready=1 → all enables 0 during reset. First cycle after reset: state=0, mem_read=1, pc_write=1, ir_write=1.
- lw, mem_ready=1 → states 0,1,2,3,4. reg_write and instr_done only in cycle 5, mem_to_reg=01.
- FETCH with mem_ready=0 for 3 cycles → mem_read held 4 cycles. pc_write and ir_write fire once, on the 4th cycle.
- beq → cycle 3: cond_eq=1, cond_ne=0, pc_source=01, alu_op=01. bne → cond_ne=1, cond_eq=0.
- jal, JAL_LINK_EN defined → cycle 3: pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem_to_reg=10. Undefined → illegal_op in cycle 2, state=0 in cycle 3.
- Reset asserted during MEM_READ wait → mem_read=0 that cycle, next state=FETCH, no reg_write.
